// File: rtl/bcd_timekeeper.sv
// BCD time-of-day core: 1 Hz prescaler, hh:mm:ss in BCD, 12h/24h display, validated set, hh:mm alarm.
// Internal hour is always 24h BCD; the 12h view is derived combinationally at the output.
module bcd_timekeeper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [7:0] set_hour_bcd,
    input  logic [7:0] set_min_bcd,
    input  logic [7:0] set_sec_bcd,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hour_bcd,
    input  logic [7:0] alarm_min_bcd,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       tick_1hz,
    output logic       set_err,
    output logic       alarm_hit
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic             tick_q, tick_d, set_err_q, set_err_d, alarm_q, alarm_d;

    logic             tick_edge, set_legal;
    logic [8:0]       sec_inc, min_inc, hour_inc;
    logic [7:0]       nxt_hour, nxt_min, nxt_sec;

    // Returns {wrap, next}: next BCD value, wrapping to 00 after max.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [8:0] r;
        if (v == max)
            r = 9'h100;
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign tick_edge = (cnt_q == DIV_W'(TICK_DIV - 1));

    assign set_legal = (set_hour_bcd[3:0] <= 4'd9) && (set_hour_bcd <= 8'h23) &&
                       (set_min_bcd[3:0]  <= 4'd9) && (set_min_bcd[7:4] <= 4'd5) &&
                       (set_sec_bcd[3:0]  <= 4'd9) && (set_sec_bcd[7:4] <= 4'd5);

    always_comb begin
        sec_inc  = bcd_inc(sec_q, 8'h59);
        min_inc  = sec_inc[8] ? bcd_inc(min_q, 8'h59) : {1'b0, min_q};
        hour_inc = min_inc[8] ? bcd_inc(hour_q, 8'h23) : {1'b0, hour_q};
        nxt_sec  = sec_inc[7:0];
        nxt_min  = min_inc[7:0];
        nxt_hour = hour_inc[7:0];
    end

    always_comb begin
        cnt_d     = tick_edge ? '0 : cnt_q + DIV_W'(1);
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        tick_d    = 1'b0;
        set_err_d = 1'b0;
        alarm_d   = 1'b0;
        if (set_valid && set_legal) begin
            // A legal set restarts the second and swallows any coincident tick.
            cnt_d  = '0;
            hour_d = set_hour_bcd;
            min_d  = set_min_bcd;
            sec_d  = set_sec_bcd;
        end else begin
            set_err_d = set_valid;
            if (tick_edge) begin
                hour_d  = nxt_hour;
                min_d   = nxt_min;
                sec_d   = nxt_sec;
                tick_d  = 1'b1;
                alarm_d = alarm_en && (nxt_hour == alarm_hour_bcd) &&
                          (nxt_min == alarm_min_bcd) && (nxt_sec == 8'h00);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            hour_q    <= 8'h00;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            tick_q    <= 1'b0;
            set_err_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            set_err_q <= set_err_d;
            alarm_q   <= alarm_d;
        end
    end

    logic [4:0] hour_bin, h12, h12_lo;
    always_comb begin
        hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        h12      = hour_bin - 5'd12;
        h12_lo   = h12 - 5'd10;
        if (!mode_12h)
            hour_bcd = hour_q;
        else if (hour_q == 8'h00)
            hour_bcd = 8'h12;
        else if (hour_q <= 8'h12)
            hour_bcd = hour_q;
        else if (h12 >= 5'd10)
            hour_bcd = {4'h1, h12_lo[3:0]};
        else
            hour_bcd = {4'h0, h12[3:0]};
    end

    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign pm        = (hour_q >= 8'h12);
    assign tick_1hz  = tick_q;
    assign set_err   = set_err_q;
    assign alarm_hit = alarm_q;

endmodule
